model_store: RTL
================

Name: model_store

Overview:
- Parametrised successor to the model buffer: stores triangle records for up to MAX_MODELS models in one shared block-RAM pool.
- Triangle width is generic and split into BRAM lanes of LANE_W bits.
- Write side appends triangles to one open model at a time and closes it with an explicit last flag.
- Read side takes a model id and streams the whole model out with a last marker, full throughput under backpressure. Sits between the host-command decoder and the transform pipeline.

Parameters:
- MAX_MODELS, 16, number of registry entries.
- DEPTH, 1024, total triangle slots in the pool.
- TRI_W, 261, bits per triangle record.
- LANE_W, 72, bits per BRAM lane; lanes = ceil(TRI_W/LANE_W), last lane holds the remainder.
- MODEL_W, 8, width of the external model-id fields; id is truncated to clog2(MAX_MODELS) bits.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted when high with wr_valid.
- wr_model  in  MODEL_W  target model id.
- wr_data  in  TRI_W  triangle record.
- wr_last  in  1  beat is the final triangle of the model; closes it.
- rd_req_valid  in  1  stream request valid.
- rd_req_ready  out  1  request accepted.
- rd_req_model  in  MODEL_W  model to stream.
- rd_out_valid  out  1  output beat valid.
- rd_out_ready  in  1  downstream accepts beat.
- rd_out_data  out  TRI_W  triangle record.
- rd_out_last  out  1  final triangle of the model.
- rd_out_model  out  MODEL_W  id of the model being streamed.
- free_slots  out  clog2(DEPTH)+1  DEPTH minus next free address.
- err  out  1  one-cycle pulse on a rejected read request.

Behaviour:
- Reset: all registry entries EMPTY, base=0, size=0; next_addr=0; no open model; read FSM IDLE; skid buffer empty. Outputs: rd_out_valid=0, rd_out_last=0, err=0, rd_req_ready=1, free_slots=DEPTH.
- Registry entry per model: base, size (clog2(DEPTH)+1 bits), state EMPTY/WRITING/READY.
- wr_ready=1 only when all of the following hold:
  - target is EMPTY with no model open, or target is the open WRITING model; and
  - next_addr<DEPTH.
- wr_ready is low when the target is READY, when a different model is open, or when the pool is full.
- Accepted beat:
  - data is written to lanes at next_addr; next_addr increments; size increments.
  - EMPTY->WRITING records base=next_addr and marks the model open.
  - wr_last: state becomes READY and the open marker clears. A single-beat model (first beat with wr_last) goes directly EMPTY->READY.
- Full pool: wr_ready stays low until rst; the open model stays WRITING.
- Read FSM:
  - IDLE: rd_req_ready=1. On accept, if the model is READY: load rd_addr=base and remaining=size, latch the id, go to STREAM. Otherwise pulse err the next cycle, emit no beats, stay IDLE.
  - STREAM: rd_req_ready=0. Issue one BRAM read per cycle while the 2-entry skid has space, counting in-flight reads. After the final address is issued and the final beat leaves the skid, return to IDLE.
  - rd_out_last is set on the beat carrying index size-1.
- Latency: first rd_out_valid appears 2 cycles after request acceptance. Throughput is 1 beat/cycle while rd_out_ready=1. rd_out_ready may drop on any cycle with no data loss or duplication.
- Output data is stable while rd_out_valid=1 and rd_out_ready=0.
- Simultaneous write and read: legal. A streamed model is READY and therefore immutable, so there are no address hazards.
- Asserting rst mid-stream or mid-write drops everything and returns to the reset values.

Optional Feature:
- MODEL_STORE_ABORT_EN: adds input wr_abort (1 bit).
  - If high while a model is open: the open model returns to EMPTY with size=0, and next_addr rewinds to its base (the open model is always the highest allocation).
  - wr_ready=0 during the abort cycle; with no open model, wr_abort is ignored.
- Without the macro: no port; an open model can only be closed by wr_last or rst.

Decomposition:
- types_pkg: model_store_state_t enum (EMPTY/WRITING/READY) and a localparam default for MODEL_W. Structs remain local to the module because they are sized by parameters.
- Sub-module model_store_bank: one LANE_W x DEPTH simple-dual-port RAM with 1-cycle synchronous read, instantiated once per lane in a generate loop.

Test Plan:
- Write model 3 with 4 beats (data 0xA0..0xA3, last on the 4th), then request model 3 with ready held high -> beats A0..A3 on consecutive cycles, first beat 2 cycles after accept, last=1 only on A3, free_slots=DEPTH-4.
- Open model 1 (no last) and then write to model 2 -> wr_ready=0. Finish model 1 with wr_last, write to model 1 again -> wr_ready=0 (READY).
- Request EMPTY model 5 -> err pulses once, no rd_out_valid, rd_req_ready back to 1.
- Stream 8 beats with rd_out_ready toggling 1,0,0,1,... -> exactly 8 beats in order, no duplicates, data stable while stalled.
- With DEPTH=8, write 8 beats to model 0 without last -> wr_ready=0 on the 9th, free_slots=0. Assert rst mid-stream -> rd_out_valid=0 and registry EMPTY on the next cycle.
- ABORT_EN: write 3 beats to model 2, pulse wr_abort -> free_slots restored to DEPTH, model 2 writable again from base 0.

Source files
------------

// File: rtl/model_store_pkg.sv
// model_store_pkg: shared registry/read-FSM state types and id-width default for model_store
package model_store_pkg;
  typedef enum logic [1:0] {EMPTY, WRITING, READY} model_store_state_t;
  typedef enum logic {RD_IDLE, RD_STREAM} model_store_rd_t;
  localparam int MODEL_W_DEF = 8;
endpackage

// File: rtl/model_store_bank.sv
// model_store_bank: one lane of the triangle pool, simple dual-port RAM with 1-cycle synchronous read
module model_store_bank #(
  parameter int W = 72,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/model_store.sv
// model_store: shared BRAM pool of triangle models, append writes and streamed reads; MODEL_STORE_ABORT_EN adds wr_abort
module model_store
  import model_store_pkg::*;
#(
  parameter int MAX_MODELS = 16,
  parameter int DEPTH = 1024,
  parameter int TRI_W = 261,
  parameter int LANE_W = 72,
  parameter int MODEL_W = MODEL_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [MODEL_W-1:0]       wr_model,
  input  logic [TRI_W-1:0]         wr_data,
  input  logic                     wr_last,
`ifdef MODEL_STORE_ABORT_EN
  input  logic                     wr_abort,
`endif
  input  logic                     rd_req_valid,
  output logic                     rd_req_ready,
  input  logic [MODEL_W-1:0]       rd_req_model,
  output logic                     rd_out_valid,
  input  logic                     rd_out_ready,
  output logic [TRI_W-1:0]         rd_out_data,
  output logic                     rd_out_last,
  output logic [MODEL_W-1:0]       rd_out_model,
  output logic [$clog2(DEPTH):0]   free_slots,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam int IW = MAX_MODELS > 1 ? $clog2(MAX_MODELS) : 1;
  localparam int LANES = (TRI_W + LANE_W - 1) / LANE_W;
  typedef struct packed {
    logic             last;
    logic [TRI_W-1:0] data;
  } beat_t;
  model_store_state_t st [MAX_MODELS];
  logic [AW-1:0] base [MAX_MODELS];
  logic [SW-1:0] size [MAX_MODELS];
  logic [SW-1:0] next_addr, rem;
  logic [AW-1:0] rd_addr;
  logic open_v;
  logic [IW-1:0] open_id, wid, rid;
  logic abort, wr_fire, req_ok, issue, pend, pend_last, fire, pop, push, done, qi;
  logic [1:0] cnt;
  beat_t q [2];
  beat_t head;
  logic [TRI_W-1:0] ram_q;
  logic [MODEL_W-1:0] cur_model;
  model_store_rd_t rs, rs_nxt;
  logic unused_id_bits;
  assign wid = wr_model[IW-1:0];
  assign rid = rd_req_model[IW-1:0];
  assign unused_id_bits = ^{wr_model[MODEL_W-1:IW], rd_req_model[MODEL_W-1:IW]};
`ifdef MODEL_STORE_ABORT_EN
  assign abort = wr_abort && open_v;
`else
  assign abort = 1'b0;
`endif
  assign wr_ready = !abort && next_addr < SW'(DEPTH) &&
                    ((st[wid] == EMPTY && !open_v) || (open_v && open_id == wid));
  assign wr_fire = wr_valid && wr_ready;
  assign free_slots = SW'(DEPTH) - next_addr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < MAX_MODELS; i++) begin
        st[i] <= EMPTY;
        base[i] <= '0;
        size[i] <= '0;
      end
      next_addr <= '0;
      open_v <= 1'b0;
      open_id <= '0;
    end else if (abort) begin
      st[open_id] <= EMPTY;
      size[open_id] <= '0;
      next_addr <= {1'b0, base[open_id]};
      open_v <= 1'b0;
    end else if (wr_fire) begin
      next_addr <= next_addr + SW'(1);
      size[wid] <= size[wid] + SW'(1);
      if (st[wid] == EMPTY) base[wid] <= next_addr[AW-1:0];
      st[wid] <= wr_last ? READY : WRITING;
      open_v <= !wr_last;
      open_id <= wid;
    end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int LO = g * LANE_W;
    localparam int LW = (g == LANES - 1) ? TRI_W - LO : LANE_W;
    model_store_bank #(.W(LW), .DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .we    (wr_fire),
      .waddr (next_addr[AW-1:0]),
      .wdata (wr_data[LO +: LW]),
      .re    (issue),
      .raddr (rd_addr),
      .rdata (ram_q[LO +: LW])
    );
  end
  assign rd_req_ready = rs == RD_IDLE;
  assign req_ok = rd_req_valid && rs == RD_IDLE && st[rid] == READY;
  assign issue = rs == RD_STREAM && rem != '0 && (cnt + {1'b0, pend}) < 2'd2;
  assign rd_out_valid = cnt != 2'd0 || pend;
  assign head = cnt != 2'd0 ? q[0] : beat_t'({pend_last, ram_q});
  assign rd_out_data = head.data;
  assign rd_out_last = rd_out_valid && head.last;
  assign rd_out_model = cur_model;
  assign fire = rd_out_valid && rd_out_ready;
  assign pop = cnt != 2'd0 && fire;
  assign push = pend && !(cnt == 2'd0 && fire);
  assign qi = cnt[0] ^ pop;
  assign done = rem == '0 && (cnt + {1'b0, pend}) == {1'b0, fire};
  always_comb rs_nxt = rs == RD_IDLE ? (req_ok ? RD_STREAM : RD_IDLE) : (done ? RD_IDLE : RD_STREAM);
  always_ff @(posedge clk or posedge rst)
    if (rst) rs <= RD_IDLE;
    else rs <= rs_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_addr <= '0;
      rem <= '0;
      cur_model <= '0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      cnt <= 2'd0;
      q[0] <= '0;
      q[1] <= '0;
      err <= 1'b0;
    end else begin
      err <= rd_req_valid && rs == RD_IDLE && st[rid] != READY;
      if (req_ok) begin
        rd_addr <= base[rid];
        rem <= size[rid];
        cur_model <= rd_req_model;
      end else if (issue) begin
        rd_addr <= rd_addr + AW'(1);
        rem <= rem - SW'(1);
      end
      pend <= issue;
      if (issue) pend_last <= rem == SW'(1);
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (pop) q[0] <= q[1];
      if (push) q[qi] <= beat_t'({pend_last, ram_q});
    end
endmodule
